// File: rtl/riscv_core_mul_div_issue.sv
// Issue/return sequencer for the M-extension multiply/divide unit.
// It accepts one decoded M-op from execute and registers its operands towards the unit.
// It pulses the unit enable once, then waits for done.
// It captures the result and flags and offers them to writeback.
// A flushed op is dropped, and DRAIN absorbs the done of a unit that is still computing.
//
// Handshake semantics: a transfer on a valid/ready pair happens on a rising
// clock edge where both valid and ready are high. Valid never depends on ready.
// Once valid is raised, it and its payload stay stable until that transfer.
// The only exception is flush, which withdraws the payload.
module riscv_core_mul_div_issue #(
  parameter int XLEN     = 64,
  parameter int REG_ADDR = 5
) (
  input  logic                i_mul_div_issue_clk,
  input  logic                i_mul_div_issue_rst,
  input  logic                i_mul_div_issue_req_valid,
  output logic                o_mul_div_issue_req_ready,
  input  logic [XLEN-1:0]     i_mul_div_issue_srcA,
  input  logic [XLEN-1:0]     i_mul_div_issue_srcB,
  input  logic [3:0]          i_mul_div_issue_control,
  input  logic                i_mul_div_issue_isword,
  input  logic [REG_ADDR-1:0] i_mul_div_issue_rd,
  input  logic                i_mul_div_issue_flush,
  output logic                o_mul_div_issue_busy,
  output logic [XLEN-1:0]     o_mul_div_issue_unit_srcA,
  output logic [XLEN-1:0]     o_mul_div_issue_unit_srcB,
  output logic [3:0]          o_mul_div_issue_unit_control,
  output logic                o_mul_div_issue_unit_isword,
  output logic                o_mul_div_issue_unit_en,
  input  logic                i_mul_div_issue_unit_done,
  input  logic                i_mul_div_issue_unit_ovf,
  input  logic                i_mul_div_issue_unit_dbz,
  input  logic [XLEN-1:0]     i_mul_div_issue_unit_result,
  output logic                o_mul_div_issue_wb_valid,
  input  logic                i_mul_div_issue_wb_ready,
  output logic [REG_ADDR-1:0] o_mul_div_issue_wb_rd,
  output logic [XLEN-1:0]     o_mul_div_issue_wb_result,
  output logic                o_mul_div_issue_wb_ovf,
  output logic                o_mul_div_issue_wb_dbz
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_WB     = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [XLEN-1:0]     r_srcA;
  logic [XLEN-1:0]     r_srcB;
  logic [3:0]          r_control;
  logic                r_isword;
  logic [REG_ADDR-1:0] r_rd;
  logic [XLEN-1:0]     r_result;
  logic                r_ovf;
  logic                r_dbz;

  logic                w_accept;
  logic                w_capture;
  logic                w_req_ready;
  logic                w_busy;
  logic                w_unit_en;
  logic                w_wb_valid;

  // A request is taken only in IDLE.
  // A flush in the same cycle wins, and the op never starts.
  assign w_accept  = (r_state == S_IDLE) && i_mul_div_issue_req_valid && !i_mul_div_issue_flush;
  // The result is kept only when done arrives in WAIT with no flush competing.
  assign w_capture = (r_state == S_WAIT) && i_mul_div_issue_unit_done && !i_mul_div_issue_flush;

  // State register
  always_ff @(posedge i_mul_div_issue_clk) begin
    if (i_mul_div_issue_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and state-decoded control outputs
  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 1'b0;
    w_busy       = 1'b1;
    w_unit_en    = 1'b0;
    w_wb_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        w_busy      = 1'b0;
        if (w_accept) begin
          w_state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // If a flush arrives before the enable, nothing has been started yet.
        w_unit_en = !i_mul_div_issue_flush;
        if (i_mul_div_issue_flush) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_mul_div_issue_unit_done) begin
          w_state_next = i_mul_div_issue_flush ? S_IDLE : S_WB;
        end else if (i_mul_div_issue_flush) begin
          // The unit is mid-computation.
          // Hold its operands until its done is absorbed.
          w_state_next = S_DRAIN;
        end
      end
      S_WB: begin
        w_wb_valid = 1'b1;
        if (i_mul_div_issue_flush || i_mul_div_issue_wb_ready) begin
          w_state_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (i_mul_div_issue_unit_done) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand registers change only when a new op is accepted.
  // This holds them stable from the enable through done.
  always_ff @(posedge i_mul_div_issue_clk) begin
    if (i_mul_div_issue_rst) begin
      r_srcA    <= '0;
      r_srcB    <= '0;
      r_control <= '0;
      r_isword  <= 1'b0;
      r_rd      <= '0;
    end else if (w_accept) begin
      r_srcA    <= i_mul_div_issue_srcA;
      r_srcB    <= i_mul_div_issue_srcB;
      r_control <= i_mul_div_issue_control;
      r_isword  <= i_mul_div_issue_isword;
      r_rd      <= i_mul_div_issue_rd;
    end
  end

  // Result and flags are captured on an accepted done.
  // The flags are passed through and never trap.
  always_ff @(posedge i_mul_div_issue_clk) begin
    if (i_mul_div_issue_rst) begin
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_dbz    <= 1'b0;
    end else if (w_capture) begin
      r_result <= i_mul_div_issue_unit_result;
      r_ovf    <= i_mul_div_issue_unit_ovf;
      r_dbz    <= i_mul_div_issue_unit_dbz;
    end
  end

  assign o_mul_div_issue_req_ready    = w_req_ready;
  assign o_mul_div_issue_busy         = w_busy;
  assign o_mul_div_issue_unit_en      = w_unit_en;
  assign o_mul_div_issue_unit_srcA    = r_srcA;
  assign o_mul_div_issue_unit_srcB    = r_srcB;
  assign o_mul_div_issue_unit_control = r_control;
  assign o_mul_div_issue_unit_isword  = r_isword;
  assign o_mul_div_issue_wb_valid     = w_wb_valid;
  assign o_mul_div_issue_wb_rd        = r_rd;
  assign o_mul_div_issue_wb_result    = r_result;
  assign o_mul_div_issue_wb_ovf       = r_ovf;
  assign o_mul_div_issue_wb_dbz       = r_dbz;

endmodule

// File: tb/tb_riscv_core_mul_div_issue.sv
// Testbench for riscv_core_mul_div_issue.
// The behavioural mul/div unit model has programmable latency.
// A scoreboard queue holds the expected writebacks in order.
module tb_riscv_core_mul_div_issue;

  localparam int W = 71;  // {rd, result, ovf, dbz}
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MIN32 = 64'hFFFF_FFFF_8000_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] srcA = '0, srcB = '0;
  logic [3:0]  control = '0;
  logic        isword = 1'b0;
  logic [4:0]  rd = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic [63:0] u_a, u_b;
  logic [3:0]  u_ctl;
  logic        u_isw, u_en;
  logic        unit_done = 1'b0, unit_ovf = 1'b0, unit_dbz = 1'b0;
  logic [63:0] unit_result = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [4:0]  wb_rd;
  logic [63:0] wb_result;
  logic        wb_ovf, wb_dbz;

  riscv_core_mul_div_issue #(.XLEN(64), .REG_ADDR(5)) dut (
    .i_mul_div_issue_clk(clk),
    .i_mul_div_issue_rst(rst),
    .i_mul_div_issue_req_valid(req_valid),
    .o_mul_div_issue_req_ready(req_ready),
    .i_mul_div_issue_srcA(srcA),
    .i_mul_div_issue_srcB(srcB),
    .i_mul_div_issue_control(control),
    .i_mul_div_issue_isword(isword),
    .i_mul_div_issue_rd(rd),
    .i_mul_div_issue_flush(flush),
    .o_mul_div_issue_busy(busy),
    .o_mul_div_issue_unit_srcA(u_a),
    .o_mul_div_issue_unit_srcB(u_b),
    .o_mul_div_issue_unit_control(u_ctl),
    .o_mul_div_issue_unit_isword(u_isw),
    .o_mul_div_issue_unit_en(u_en),
    .i_mul_div_issue_unit_done(unit_done),
    .i_mul_div_issue_unit_ovf(unit_ovf),
    .i_mul_div_issue_unit_dbz(unit_dbz),
    .i_mul_div_issue_unit_result(unit_result),
    .o_mul_div_issue_wb_valid(wb_valid),
    .i_mul_div_issue_wb_ready(wb_ready),
    .o_mul_div_issue_wb_rd(wb_rd),
    .o_mul_div_issue_wb_result(wb_result),
    .o_mul_div_issue_wb_ovf(wb_ovf),
    .o_mul_div_issue_wb_dbz(wb_dbz)
  );

  // ---------------- checking helpers ----------------
  int n_chk = 0, n_fail = 0;
  logic [W-1:0] exp_q[$];

  function automatic void check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // RISC-V M reference: returns {ovf, dbz, result}
  function automatic logic [65:0] ref_mdu(input logic [3:0] ctl, input logic isw,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  r, ua, ub, mn;
    logic signed [63:0] sa, sb;
    logic ovf, dbz;
    ovf = 1'b0; dbz = 1'b0; r = '0; p = '0;
    if (isw) begin
      sa = {{32{a[31]}}, a[31:0]}; sb = {{32{b[31]}}, b[31:0]};
      ua = {32'b0, a[31:0]};       ub = {32'b0, b[31:0]};
      mn = MIN32;
    end else begin
      sa = a; sb = b; ua = a; ub = b; mn = MIN64;
    end
    case (ctl[2:0])
      3'd0: begin p = {64'b0, ua} * {64'b0, ub}; r = p[63:0]; end
      3'd1: begin p = {{64{sa[63]}}, sa} * {{64{sb[63]}}, sb}; r = p[127:64]; end
      3'd2: begin p = {{64{sa[63]}}, sa} * {64'b0, ub}; r = p[127:64]; end
      3'd3: begin p = {64'b0, ua} * {64'b0, ub}; r = p[127:64]; end
      3'd4, 3'd6: begin
        if (sb == 0) begin
          dbz = 1'b1; r = (ctl[2:0] == 3'd4) ? 64'hFFFF_FFFF_FFFF_FFFF : sa;
        end else if (sa == mn && sb == -64'sd1) begin
          ovf = 1'b1; r = (ctl[2:0] == 3'd4) ? mn : 64'd0;
        end else begin
          r = (ctl[2:0] == 3'd4) ? sa / sb : sa % sb;
        end
      end
      default: begin
        if (ub == 0) begin
          dbz = 1'b1; r = (ctl[2:0] == 3'd5) ? 64'hFFFF_FFFF_FFFF_FFFF : ua;
        end else begin
          r = (ctl[2:0] == 3'd5) ? ua / ub : ua % ub;
        end
      end
    endcase
    if (isw) r = {{32{r[31]}}, r[31:0]};
    return {ovf, dbz, r};
  endfunction

  // ---------------- unit model + monitor state ----------------
  int          unit_lat = 1, stall_req = 0;
  logic [63:0] iss_a, iss_b;
  logic [3:0]  iss_ctl;
  logic        iss_isw;
  bit          pend = 0, inj_req = 0, m_done_inj = 0;
  int          done_cyc = 0, en_cnt = 0, last_en_cyc = -1;
  logic [63:0] m_a, m_b, m_res;
  logic [3:0]  m_ctl;
  logic        m_isw, m_ovf, m_dbz;
  logic [65:0] m_r;

  int          wbv_cnt = 0, busy_cnt = 0, hs_cnt = 0, wb_first_cyc = -1;
  logic [4:0]  last_hs_rd = '0;
  logic [63:0] last_hs_result = '0;
  logic        last_hs_dbz = 1'b0;
  logic        prev_wbv = 1'b0, prev_rdy = 1'b0, prev_flush = 1'b0;
  logic [W-1:0] prev_data = '0, act_w, exp_w;
  bit          in_wb = 0;
  int          scnt = 0;

  // Unit done/result driver: garbage result except on the done cycle
  always @(posedge clk) begin
    #1;
    if ((pend && cyc == done_cyc) || inj_req) begin
      unit_done = 1'b1; m_done_inj = inj_req;
      unit_result = m_res; unit_ovf = m_ovf; unit_dbz = m_dbz;
    end else begin
      unit_done = 1'b0; m_done_inj = 0;
      unit_result = {$urandom, $urandom}; unit_ovf = 1'b0; unit_dbz = 1'b0;
    end
  end

  // Writeback ready driver: holds ready low for stall_req cycles of each WB
  always @(posedge clk) begin
    #1;
    if (wb_valid) begin
      if (!in_wb) begin in_wb = 1; scnt = stall_req; end
      if (scnt > 0) begin wb_ready = 1'b0; scnt--; end
      else wb_ready = 1'b1;
    end else begin
      in_wb = 0; wb_ready = 1'b1;
    end
  end

  // Unit model sampling and writeback monitor
  always @(negedge clk) begin
    if (rst) begin
      pend = 0; prev_wbv = 1'b0;
    end else begin
      if (pend) begin
        check("unit_hold_ab", {u_a, u_b}, {m_a, m_b});
        check("unit_hold_ctl", {u_ctl, u_isw}, {m_ctl, m_isw});
        if (unit_done) pend = 0;
      end
      if (u_en) begin
        check("en_while_unit_busy", pend, 0);
        check("unit_operands", {u_a, u_b}, {iss_a, iss_b});
        check("unit_ctl", {u_ctl, u_isw}, {iss_ctl, iss_isw});
        m_a = u_a; m_b = u_b; m_ctl = u_ctl; m_isw = u_isw;
        m_r = ref_mdu(u_ctl, u_isw, u_a, u_b);
        m_res = m_r[63:0]; m_ovf = m_r[65]; m_dbz = m_r[64];
        pend = 1; done_cyc = cyc + unit_lat; en_cnt++; last_en_cyc = cyc;
      end
      if (unit_done && !m_done_inj)
        check("done_protocol", {busy, wb_valid, u_en}, 3'b100);
      if (wb_valid) wbv_cnt++;
      if (busy) busy_cnt++;
      if (wb_valid && !prev_wbv) wb_first_cyc = cyc;
      act_w = {wb_rd, wb_result, wb_ovf, wb_dbz};
      if (prev_wbv && !prev_rdy && !prev_flush) begin
        check("wb_hold_valid", wb_valid, 1);
        check("wb_hold_data", act_w, prev_data);
      end
      if (wb_valid && wb_ready && !flush) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 1, 0);
        end else begin
          exp_w = exp_q.pop_front();
          check("wb_data", act_w, exp_w);
        end
        hs_cnt++;
        last_hs_rd = wb_rd; last_hs_result = wb_result; last_hs_dbz = wb_dbz;
      end
      prev_wbv = wb_valid; prev_rdy = wb_ready; prev_flush = flush; prev_data = act_w;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 400) begin @(posedge clk); #1; n++; end
    if (!req_ready) check("req_ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [3:0] ctl, input logic isw, input logic [63:0] a,
                      input logic [63:0] b, input logic [4:0] d, input int lat,
                      input int stall, input bit expect_wb, output int acc);
    logic [65:0] r;
    wait_ready();
    unit_lat = lat; stall_req = stall;
    iss_a = a; iss_b = b; iss_ctl = ctl; iss_isw = isw;
    req_valid = 1'b1; srcA = a; srcB = b; control = ctl; isword = isw; rd = d;
    acc = cyc;
    if (expect_wb) begin
      r = ref_mdu(ctl, isw, a, b);
      exp_q.push_back({d, r[63:0], r[65], r[64]});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    srcA = {$urandom, $urandom}; srcB = {$urandom, $urandom};
    control = 4'($urandom_range(0, 15)); isword = 1'($urandom_range(0, 1));
    rd = 5'($urandom_range(0, 31));
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return MIN64;
      3: return 64'($urandom_range(0, 9));
      4: return MIN32;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int acc, acc2, snap, snap2;
    logic [2:0] f3;
    logic b3, iw;

    rst = 1'b1;
    step(3);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_outs", {busy, u_en, wb_valid}, 3'b000);
    check("rst_regs", {u_a, u_b, u_ctl, u_isw, wb_rd, wb_result, wb_ovf, wb_dbz}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1);

    // MUL 3 * -5, L=1: en at +1, wb_valid at +3
    send(4'd0, 1'b0, 64'd3, -64'sd5, 5'd1, 1, 0, 1, acc);
    wait_ready();
    check("mul_en_cycle", last_en_cyc, acc + 1);
    check("mul_wb_cycle", wb_first_cyc, acc + 3);
    check("mul_result", last_hs_result, 64'hFFFF_FFFF_FFFF_FFF1);

    // DIVU 100 / 0, L=64: 66 busy cycles, all-ones quotient, dbz, rd echoed
    busy_cnt = 0;
    send(4'd5, 1'b0, 64'd100, 64'd0, 5'd17, 64, 0, 1, acc);
    wait_ready();
    check("divu_busy_cycles", busy_cnt, 66);
    check("divu_result", last_hs_result, 64'hFFFF_FFFF_FFFF_FFFF);
    check("divu_dbz", last_hs_dbz, 1);
    check("divu_rd", last_hs_rd, 17);

    // DIV L=10, flush at 4th WAIT cycle -> DRAIN, no writeback
    wbv_cnt = 0;
    send(4'd4, 1'b0, -64'sd77, 64'd7, 5'd9, 10, 0, 0, acc);
    step(4);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(5);
    @(negedge clk);
    check("drain_ready_at_done", {req_ready, busy}, 2'b01);
    step(1);
    @(negedge clk);
    check("drain_ready_after_done", req_ready, 1);
    check("drain_no_wb", wbv_cnt, 0);

    // MULW with 3 stall cycles: valid held 4 cycles, one handshake
    wbv_cnt = 0; snap = hs_cnt;
    send(4'd0, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0013, 5'd3, 2, 3, 1, acc);
    wait_ready();
    check("mulw_valid_cycles", wbv_cnt, 4);
    check("mulw_handshakes", hs_cnt - snap, 1);

    // Back-to-back rd=5 then rd=6, L=2
    snap = hs_cnt;
    send(4'd1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 5'd5, 2, 0, 1, acc);
    send(4'd6, 1'b0, {$urandom, $urandom}, 64'd13, 5'd6, 2, 0, 1, acc2);
    check("b2b_interval_l2", acc2 - acc, 5);
    wait_ready();
    check("b2b_handshakes", hs_cnt - snap, 2);
    check("b2b_last_rd", last_hs_rd, 6);
    send(4'd3, 1'b0, 64'd7, 64'd9, 5'd7, 1, 0, 1, acc);
    send(4'd7, 1'b1, 64'd50, 64'd7, 5'd8, 1, 0, 1, acc2);
    check("min_issue_interval", acc2 - acc, 4);
    wait_ready();

    // Request with flush in IDLE: not accepted
    snap2 = en_cnt;
    req_valid = 1'b1; flush = 1'b1;
    step(1);
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle_flush_not_taken", {busy, 32'(en_cnt - snap2)}, 33'd0);

    // Flush in LAUNCH: no enable issued
    snap2 = en_cnt;
    send(4'd0, 1'b0, 64'd2, 64'd2, 5'd10, 3, 0, 0, acc);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    @(negedge clk);
    check("launch_flush", {busy, 32'(en_cnt - snap2)}, 33'd0);

    // Flush and done in the same WAIT cycle: discarded
    wbv_cnt = 0;
    send(4'd2, 1'b0, 64'd5, 64'd6, 5'd11, 3, 0, 0, acc);
    step(3);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    @(negedge clk);
    check("flush_with_done", {busy, 32'(wbv_cnt)}, 33'd0);

    // Flush in WB (ready held low): dropped, no handshake
    snap = hs_cnt;
    send(4'd0, 1'b0, 64'd4, 64'd4, 5'd12, 1, 3, 0, acc);
    step(2);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    @(negedge clk);
    check("wb_flush", {busy, 32'(hs_cnt - snap)}, 33'd0);

    // Reset in WAIT, then a stray done
    send(4'd4, 1'b0, 64'd1000, 64'd3, 5'd13, 20, 0, 0, acc);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_wait_ready", req_ready, 1);
    check("rst_wait_outs", {busy, u_en, wb_valid}, 3'b000);
    check("rst_wait_regs", {u_a, u_b, u_ctl}, '0);
    inj_req = 1;
    @(negedge clk);
    inj_req = 0;
    @(negedge clk);
    check("late_done_ignored", {busy, wb_valid, req_ready}, 3'b001);
    step(1);

    // Randomized ops
    for (int i = 0; i < 30; i++) begin
      f3 = 3'($urandom_range(0, 7));
      iw = 1'($urandom_range(0, 1));
      b3 = 1'($urandom_range(0, 1));
      if (iw && (f3 inside {3'd1, 3'd2, 3'd3})) f3 = 3'd0;
      send({b3, f3}, iw, pick(), pick(), 5'($urandom_range(0, 31)),
           $urandom_range(1, 8), $urandom_range(0, 3), 1, acc);
    end
    wait_ready();
    step(2);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
